// File: rtl/edge_detect_bank.sv
// edge_detect_bank: multi-channel synchronised edge detector with per-channel
// edge mode, stretched output pulse, sticky flag and saturating event counter.
module edge_detect_bank #(
    parameter int unsigned CHANNELS    = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned STRETCH     = 1,
    parameter int unsigned CNT_WIDTH   = 8,
    localparam int unsigned SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  Clock,
    input  logic                  ResetN,
    input  logic [CHANNELS-1:0]   DataIn,
    input  logic [2*CHANNELS-1:0] ModeSel,
    input  logic [CHANNELS-1:0]   StickyClr,
    input  logic [SEL_W-1:0]      CountSel,
    input  logic                  CountClr,
    output logic [CHANNELS-1:0]   Edge,
    output logic [CHANNELS-1:0]   Sticky,
    output logic [CNT_WIDTH-1:0]  Count,
    output logic                  AnyEdge
);

    localparam int unsigned WARM_W = $clog2(SYNC_STAGES + 2);

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } mode_t;

    logic [CHANNELS-1:0]  sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0]  s_lvl;
    logic [CHANNELS-1:0]  prev_q;
    logic [CHANNELS-1:0]  evt;
    logic [CHANNELS-1:0]  evt_q;
    logic [WARM_W-1:0]    warm_q;
    logic [3:0]           stretch_q [CHANNELS];
    logic [3:0]           stretch_d [CHANNELS];
    logic [CNT_WIDTH-1:0] cnt_q [CHANNELS];
    logic [CNT_WIDTH-1:0] sel_cnt;

    assign s_lvl = sync_q[SYNC_STAGES-1];

    // Detection is masked while warm_q counts down, so lines held high through
    // reset never look like a rising edge.
    always_comb begin
        evt = '0;
        for (int unsigned n = 0; n < CHANNELS; n++) begin
            case (mode_t'(ModeSel[2*n +: 2]))
                MODE_RISE: evt[n] = s_lvl[n] & ~prev_q[n];
                MODE_FALL: evt[n] = ~s_lvl[n] & prev_q[n];
                MODE_BOTH: evt[n] = s_lvl[n] ^ prev_q[n];
                default:   evt[n] = 1'b0;
            endcase
        end
        if (warm_q != '0) begin
            evt = '0;
        end
    end

    always_comb begin
        for (int unsigned n = 0; n < CHANNELS; n++) begin
            stretch_d[n] = stretch_q[n];
            if (evt_q[n]) begin
                stretch_d[n] = 4'(STRETCH);
            end else if (stretch_q[n] != '0) begin
                stretch_d[n] = stretch_q[n] - 4'd1;
            end
        end
    end

    always_comb begin
        sel_cnt = '0;
        for (int unsigned n = 0; n < CHANNELS; n++) begin
            if (CountSel == SEL_W'(n)) begin
                sel_cnt = cnt_q[n];
            end
        end
    end

    // evt is registered once before use; that stage sets the edge-to-Edge latency.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            prev_q  <= '0;
            evt_q   <= '0;
            warm_q  <= WARM_W'(SYNC_STAGES + 1);
            AnyEdge <= 1'b0;
        end else begin
            sync_q[0] <= DataIn;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            prev_q <= s_lvl;
            evt_q  <= evt;
            if (warm_q != '0) begin
                warm_q <= warm_q - WARM_W'(1);
            end
            AnyEdge <= |evt_q;
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            for (int unsigned n = 0; n < CHANNELS; n++) begin
                stretch_q[n] <= '0;
                cnt_q[n]     <= '0;
            end
            Edge   <= '0;
            Sticky <= '0;
        end else begin
            for (int unsigned n = 0; n < CHANNELS; n++) begin
                stretch_q[n] <= stretch_d[n];
                Edge[n]      <= (stretch_d[n] != '0);
                if (evt_q[n]) begin
                    Sticky[n] <= 1'b1;
                end else if (StickyClr[n]) begin
                    Sticky[n] <= 1'b0;
                end
                // A clear coinciding with an event keeps that event.
                if (CountClr && (CountSel == SEL_W'(n))) begin
                    cnt_q[n] <= evt_q[n] ? CNT_WIDTH'(1) : '0;
                end else if (evt_q[n] && (cnt_q[n] != '1)) begin
                    cnt_q[n] <= cnt_q[n] + CNT_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            Count <= '0;
        end else begin
            Count <= sel_cnt;
        end
    end

endmodule
